pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 4-stage RISC-V pipeline: IF, ID, EX, WB, with data memory accessed in WB. It generates every pipeline-register enable and flush, and the EX operand forwarding selects. It freezes the pipeline while data memory is not ready, and halts the core on ECALL/EBREAK or a memory timeout. It keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF-ID-EX-WB pipeline:
// enables, flushes, forwarding, memory freeze/timeout, halt, perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             wb_mem_op,
    input  logic             dmem_ready,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exwb_en,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_freeze;
    logic          w_loaduse;
    logic          w_eval;
    logic          w_halt_set;
    logic          w_err_set;
    logic          w_flush_inc;
    logic          w_stall_inc;
    logic          w_tmo_hit;

    // ex_regwrite is implied by ex_memread for a load; kept for interface completeness
    logic          w_unused;
    assign w_unused = ex_regwrite;

    assign w_freeze  = wb_mem_op & ~dmem_ready;
    assign w_loaduse = ex_memread & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign w_tmo_hit = ({1'b0, r_tmo} >= (TW + 1)'(MEM_TIMEOUT - 1));

    assign fwd_a = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == ex_rs1);
    assign fwd_b = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == ex_rs2);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exwb_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        w_next      = r_state;
        w_tmo_nxt   = r_tmo;
        w_eval      = 1'b0;
        w_halt_set  = 1'b0;
        w_err_set   = 1'b0;
        w_flush_inc = 1'b0;

        unique case (r_state)
            S_RUN: w_eval = 1'b1;
            S_MEMWAIT: begin
                if (!dmem_ready) begin
                    {pc_en, ifid_en, idex_en, exwb_en} = 4'b0000;
                    w_tmo_nxt = r_tmo + TW'(1);
                    if (w_tmo_hit) begin
                        w_next     = S_HALT;
                        w_err_set  = 1'b1;
                        w_halt_set = 1'b1;
                    end
                end else begin
                    w_eval    = 1'b1;
                    w_next    = S_RUN;
                    w_tmo_nxt = '0;
                end
            end
            default: {pc_en, ifid_en, idex_en, exwb_en} = 4'b0000;
        endcase

        // RUN-style evaluation, also used for the MEMWAIT release cycle
        if (w_eval) begin
            if (w_freeze) begin
                {pc_en, ifid_en, idex_en, exwb_en} = 4'b0000;
                w_next    = S_MEMWAIT;
                w_tmo_nxt = TW'(1);
            end else if (wb_halt) begin
                {pc_en, ifid_en, idex_en} = 3'b000;
                w_next     = S_HALT;
                w_halt_set = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                w_flush_inc = 1'b1;
            end else if (w_loaduse) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (!reset) begin
            {pc_en, ifid_en, idex_en, exwb_en} = 4'b0000;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign w_stall_inc = (r_state != S_HALT) & ~pc_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_tmo     <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_tmo   <= w_tmo_nxt;
            if (w_halt_set) halted <= 1'b1;
            if (w_err_set) mem_err <= 1'b1;
            if (w_stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (w_flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push expected
// outputs, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, wb_rd;
    logic id_uses_rs2, ex_regwrite, ex_memread, ex_branch_taken;
    logic wb_regwrite, wb_mem_op, dmem_ready, wb_halt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en;
    logic fwd_a, fwd_b, halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_mem_op(wb_mem_op),
        .dmem_ready(dmem_ready), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exwb_en(exwb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] en;
        logic [3:0] m;
        logic [1:0] fl;
        logic [1:0] fwd;
        logic       hl;
        logic       er;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic done = 1'b0;

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; ex_branch_taken = 0;
        wb_rd = 0; wb_regwrite = 0; wb_mem_op = 0;
        dmem_ready = 1; wb_halt = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    // en = {pc,ifid,idex,exwb}, fl = {ifid_flush,idex_flush}, fwd = {a,b}
    task automatic exp(input string n, input logic [3:0] en,
                       input logic [1:0] fl, input logic [1:0] fwd,
                       input logic hl, input logic er,
                       input int sc, input int fc,
                       input logic [3:0] m = 4'hF);
        exp_t e;
        e.name = n; e.en = en; e.m = m; e.fl = fl; e.fwd = fwd;
        e.hl = hl; e.er = er; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [3:0] g_en;
            e = q.pop_front();
            g_en = {pc_en, ifid_en, idex_en, exwb_en};
            n_chk++;
            if ((((g_en ^ e.en) & e.m) != 4'h0) ||
                ({ifid_flush, idex_flush} !== e.fl) ||
                ({fwd_a, fwd_b} !== e.fwd) ||
                (halted !== e.hl) || (mem_err !== e.er) ||
                (stall_cnt !== CNT_W'(e.sc)) ||
                (flush_cnt !== CNT_W'(e.fc))) begin
                n_err++;
                $display("FAIL %s: got en=%b fl=%b fwd=%b hl=%b er=%b sc=%0d fc=%0d ; need en=%b(mask %b) fl=%b fwd=%b hl=%b er=%b sc=%0d fc=%0d",
                         e.name, g_en, {ifid_flush, idex_flush}, {fwd_a, fwd_b},
                         halted, mem_err, stall_cnt, flush_cnt,
                         e.en, e.m, e.fl, e.fwd, e.hl, e.er, e.sc, e.fc);
            end
        end
    end

    initial begin
        idle();
        nxt(); reset = 0; exp("rst0", 4'b0000, 2'b11, 2'b00, 0, 0, 0, 0);
        nxt(); reset = 0; exp("rst1", 4'b0000, 2'b11, 2'b00, 0, 0, 0, 0);
        nxt(); reset = 1; exp("normal", 4'b1111, 2'b00, 2'b00, 0, 0, 0, 0);

        nxt(); ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        exp("loaduse_rs1", 4'b0011, 2'b01, 2'b00, 0, 0, 0, 0);
        nxt(); exp("after_lu", 4'b1111, 2'b00, 2'b00, 0, 0, 1, 0);
        nxt(); ex_memread = 1; ex_rd = 0; id_rs1 = 0;
        exp("lu_x0", 4'b1111, 2'b00, 2'b00, 0, 0, 1, 0);
        nxt(); ex_memread = 1; ex_rd = 9; id_rs1 = 3; id_rs2 = 9; id_uses_rs2 = 1;
        exp("loaduse_rs2", 4'b0011, 2'b01, 2'b00, 0, 0, 1, 0);
        nxt(); ex_memread = 1; ex_rd = 9; id_rs1 = 3; id_rs2 = 9;
        exp("rs2_unused", 4'b1111, 2'b00, 2'b00, 0, 0, 2, 0);

        nxt(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        exp("br_over_lu", 4'b1111, 2'b11, 2'b00, 0, 0, 2, 0);
        nxt(); exp("after_br", 4'b1111, 2'b00, 2'b00, 0, 0, 2, 1);

        nxt(); wb_mem_op = 1; dmem_ready = 0;
        exp("freeze1", 4'b0000, 2'b00, 2'b00, 0, 0, 2, 1);
        nxt(); wb_mem_op = 1; dmem_ready = 0;
        exp("freeze2", 4'b0000, 2'b00, 2'b00, 0, 0, 3, 1);
        nxt(); wb_mem_op = 1; dmem_ready = 0;
        exp("freeze3", 4'b0000, 2'b00, 2'b00, 0, 0, 4, 1);
        nxt(); wb_mem_op = 1; dmem_ready = 1; ex_branch_taken = 1;
        exp("release_br", 4'b1111, 2'b11, 2'b00, 0, 0, 5, 1);
        nxt(); exp("run_again", 4'b1111, 2'b00, 2'b00, 0, 0, 5, 2);

        nxt(); wb_mem_op = 1; dmem_ready = 0;
        exp("freeze4", 4'b0000, 2'b00, 2'b00, 0, 0, 5, 2);
        nxt(); wb_mem_op = 1; ex_memread = 1; ex_rd = 6; id_rs1 = 6;
        exp("release_lu", 4'b0011, 2'b01, 2'b00, 0, 0, 6, 2);
        nxt(); exp("run_again2", 4'b1111, 2'b00, 2'b00, 0, 0, 7, 2);

        nxt(); wb_regwrite = 1; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 7;
        exp("fwd_both", 4'b1111, 2'b00, 2'b11, 0, 0, 7, 2);
        nxt(); wb_regwrite = 1; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        exp("fwd_x0", 4'b1111, 2'b00, 2'b00, 0, 0, 7, 2);
        nxt(); wb_regwrite = 1; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 3;
        exp("fwd_a_only", 4'b1111, 2'b00, 2'b10, 0, 0, 7, 2);
        nxt(); wb_regwrite = 0; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 7;
        exp("fwd_nowr", 4'b1111, 2'b00, 2'b00, 0, 0, 7, 2);
        nxt(); wb_regwrite = 1; wb_rd = 4; ex_rs2 = 4; wb_mem_op = 1; dmem_ready = 0;
        exp("fwd_b_frz", 4'b0000, 2'b00, 2'b01, 0, 0, 7, 2);
        nxt(); wb_mem_op = 1;
        exp("release_n", 4'b1111, 2'b00, 2'b00, 0, 0, 8, 2);

        nxt(); wb_halt = 1; ex_branch_taken = 1;
        exp("halt_cmt", 4'b0000, 2'b00, 2'b00, 0, 0, 8, 2, 4'b1110);
        nxt(); ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        exp("halted1", 4'b0000, 2'b00, 2'b00, 1, 0, 9, 2);
        nxt(); ex_branch_taken = 1; wb_mem_op = 1; dmem_ready = 0;
        exp("halted2", 4'b0000, 2'b00, 2'b00, 1, 0, 9, 2);
        nxt(); exp("halted3", 4'b0000, 2'b00, 2'b00, 1, 0, 9, 2);

        nxt(); reset = 0; exp("rst_h", 4'b0000, 2'b11, 2'b00, 0, 0, 0, 0);
        nxt(); reset = 1; exp("norm2", 4'b1111, 2'b00, 2'b00, 0, 0, 0, 0);

        for (int k = 1; k <= 15; k++) begin
            nxt(); wb_mem_op = 1; dmem_ready = 0;
            exp($sformatf("tmo_%0d", k), 4'b0000, 2'b00, 2'b00, 0, 0, k - 1, 0);
        end
        nxt(); wb_mem_op = 1; dmem_ready = 0;
        exp("tmo_err", 4'b0000, 2'b00, 2'b00, 1, 1, 15, 0);
        nxt(); exp("tmo_hold", 4'b0000, 2'b00, 2'b00, 1, 1, 15, 0);
        nxt(); reset = 0; exp("rst_err", 4'b0000, 2'b11, 2'b00, 0, 0, 0, 0);
        nxt(); reset = 1; exp("norm3", 4'b1111, 2'b00, 2'b00, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        #2;
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
